// File: rtl/writeback_scoreboard_escalar_pkg.sv
// Shared types and helpers for the scalar register-file writeback block.
package wb_pkg;

  localparam int unsigned WB_REGISTERS = 32;
  localparam int unsigned WB_WIDTH     = 32;
  localparam int unsigned WB_AW        = $clog2(WB_REGISTERS);
  localparam int unsigned WB_DEPTH     = 4;

  typedef logic [WB_AW-1:0]    reg_addr_t;
  typedef logic [WB_WIDTH-1:0] word_t;

  typedef struct packed {
    reg_addr_t rd;
    word_t     data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_MEM  = 2'd2
  } wb_src_e;

  // Single write port: a lone requester wins; on contention last_mem
  // decides (0 -> memory's turn, 1 -> ALU's turn).
  function automatic wb_src_e wb_arbitrate(input logic mem_req,
                                           input logic alu_req,
                                           input logic last_mem);
    wb_src_e src;
    case ({mem_req, alu_req})
      2'b10:   src = SRC_MEM;
      2'b01:   src = SRC_ALU;
      2'b11:   src = last_mem ? SRC_ALU : SRC_MEM;
      default: src = SRC_NONE;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/writeback_scoreboard_escalar_if.sv
// Issue/execute/memory-facing bundle of the writeback scoreboard.
// master = pipeline/environment side, slave = writeback block.
interface writeback_scoreboard_escalar_if;
  import wb_pkg::*;

  logic      alloc_valid;
  reg_addr_t alloc_rd;
  logic      alloc_ready;

  logic      alu_valid;
  reg_addr_t alu_rd;
  word_t     alu_data;
  logic      alu_ready;

  logic      mem_valid;
  reg_addr_t mem_rd;
  word_t     mem_data;
  logic      mem_ready;

  reg_addr_t q1;
  reg_addr_t q2;
  logic      busy1;
  logic      busy2;

  logic      we3;
  reg_addr_t a3;
  word_t     wd3;
  logic      err_unalloc;

  modport master (
    output alloc_valid, alloc_rd, alu_valid, alu_rd, alu_data,
           mem_valid, mem_rd, mem_data, q1, q2,
    input  alloc_ready, alu_ready, mem_ready, busy1, busy2,
           we3, a3, wd3, err_unalloc
  );

  modport slave (
    input  alloc_valid, alloc_rd, alu_valid, alu_rd, alu_data,
           mem_valid, mem_rd, mem_data, q1, q2,
    output alloc_ready, alu_ready, mem_ready, busy1, busy2,
           we3, a3, wd3, err_unalloc
  );

endinterface

// File: rtl/writeback_scoreboard_escalar_fifo.sv
// Load-return queue: synchronous FIFO of {rd, data}. Flags come from the
// registered count only, so a same-cycle pop never makes room for a push.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == {CW{1'b0}});
  assign head  = mem_q[rd_ptr_q];

  // Next pointers, occupancy and storage; pointers wrap modulo DEPTH.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset (empties the queue).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are don't-care while the queue is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/writeback_scoreboard_escalar.sv
// Writeback scoreboard: arbitrates ALU results and queued load returns into
// the register file's single write port and tracks per-register busy bits
// for the issue stage's RAW/WAW checks.
module writeback_scoreboard_escalar
  import wb_pkg::*;
#(
  parameter int unsigned REGISTERS = WB_REGISTERS,
  parameter int unsigned WIDTH     = WB_WIDTH,
  parameter int unsigned DEPTH     = WB_DEPTH
) (
  input logic                           clk,
  input logic                           rst,
  writeback_scoreboard_escalar_if.slave wb
);

  localparam int unsigned AW = $clog2(REGISTERS);

  logic [REGISTERS-1:0] busy_q,     busy_d;
  logic                 last_mem_q, last_mem_d;
  logic                 we3_q,      we3_d;
  logic [AW-1:0]        a3_q,       a3_d;
  logic [WIDTH-1:0]     wd3_q,      wd3_d;
  logic                 err_q,      err_d;

  wb_entry_t     mem_entry;
  wb_entry_t     fifo_head;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  wb_src_e       src;
  logic [AW-1:0] grant_rd;
  logic [WIDTH-1:0] grant_data;
  logic          alloc_ok;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (mem_entry),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // x0 is never tracked, so reserving or querying it always looks free.
  assign alloc_ok       = !busy_q[wb.alloc_rd] || (wb.alloc_rd == {AW{1'b0}});
  assign wb.alloc_ready = alloc_ok;
  assign wb.busy1       = busy_q[wb.q1] && (wb.q1 != {AW{1'b0}});
  assign wb.busy2       = busy_q[wb.q2] && (wb.q2 != {AW{1'b0}});
  assign wb.mem_ready   = !fifo_full;
  assign wb.alu_ready   = (src == SRC_ALU);
  assign wb.we3         = we3_q;
  assign wb.a3          = a3_q;
  assign wb.wd3         = wd3_q;
  assign wb.err_unalloc = err_q;

  // Queue push and write-port arbitration; a same-cycle push into an empty
  // queue is not visible at the head until the next cycle.
  always_comb begin
    mem_entry.rd   = wb.mem_rd;
    mem_entry.data = wb.mem_data;
    fifo_push      = wb.mem_valid && !fifo_full;
    src            = wb_arbitrate(!fifo_empty, wb.alu_valid, last_mem_q);
    fifo_pop       = (src == SRC_MEM);
    if (!fifo_empty && wb.alu_valid) begin
      last_mem_d = (src == SRC_MEM);
    end else begin
      last_mem_d = last_mem_q;
    end
  end

  // Retire register: load the granted result; x0 writes are consumed silently.
  always_comb begin
    grant_rd   = a3_q;
    grant_data = wd3_q;
    case (src)
      SRC_ALU: begin
        grant_rd   = wb.alu_rd;
        grant_data = wb.alu_data;
      end
      SRC_MEM: begin
        grant_rd   = fifo_head.rd;
        grant_data = fifo_head.data;
      end
      default: begin
        grant_rd   = a3_q;
        grant_data = wd3_q;
      end
    endcase
    we3_d = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    err_d = err_q;
    if (src != SRC_NONE) begin
      we3_d = (grant_rd != {AW{1'b0}});
      a3_d  = grant_rd;
      wd3_d = grant_data;
      if ((grant_rd != {AW{1'b0}}) && !busy_q[grant_rd]) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      we3_d = 1'b0;
    end
  end

  // Scoreboard: clear on the retiring write, set on an accepted reservation.
  always_comb begin
    busy_d = busy_q;
    if (we3_q) begin
      busy_d[a3_q] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (wb.alloc_valid && alloc_ok && (wb.alloc_rd != {AW{1'b0}})) begin
      busy_d[wb.alloc_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // State register; reset drops busy bits, round-robin state and any write
  // that would have retired on this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= {REGISTERS{1'b0}};
      last_mem_q <= 1'b0;
      we3_q      <= 1'b0;
      a3_q       <= {AW{1'b0}};
      wd3_q      <= {WIDTH{1'b0}};
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      last_mem_q <= last_mem_d;
      we3_q      <= we3_d;
      a3_q       <= a3_d;
      wd3_q      <= wd3_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_writeback_scoreboard_escalar.sv
// Bench for writeback_scoreboard_escalar: directed scenarios followed by a
// randomized run, every cycle compared against a transaction-level model.
module tb_writeback_scoreboard_escalar;
  import wb_pkg::*;

  logic clk;
  logic rst;

  writeback_scoreboard_escalar_if wbif ();

  writeback_scoreboard_escalar dut (
    .clk (clk),
    .rst (rst),
    .wb  (wbif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: set of busy registers, queue of pending loads, whose
  // turn it is on contention, and the expected write-port/error outputs.
  logic [31:0] m_busy;
  wb_entry_t   m_q[$];
  logic        m_turn_alu;
  logic        m_we3;
  reg_addr_t   m_a3;
  word_t       m_wd3;
  logic        m_err;
  logic        m_known     = 1'b0;
  logic        m_alu_taken = 1'b1;

  wb_entry_t   fifo_order[$];
  logic        watch_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_alu_win();
    return wbif.alu_valid && ((m_q.size() == 0) || m_turn_alu);
  endfunction

  task automatic model_check();
    if (m_known) begin
      chk("alloc_ready", 32'(wbif.alloc_ready),
          32'((wbif.alloc_rd == 5'd0) || !m_busy[wbif.alloc_rd]));
      chk("busy1", 32'(wbif.busy1), 32'((wbif.q1 != 5'd0) && m_busy[wbif.q1]));
      chk("busy2", 32'(wbif.busy2), 32'((wbif.q2 != 5'd0) && m_busy[wbif.q2]));
      chk("mem_ready", 32'(wbif.mem_ready), 32'(m_q.size() < 4));
      chk("alu_ready", 32'(wbif.alu_ready), 32'(exp_alu_win()));
      chk("we3", 32'(wbif.we3), 32'(m_we3));
      chk("a3", 32'(wbif.a3), 32'(m_a3));
      chk("wd3", wbif.wd3, m_wd3);
      chk("err_unalloc", 32'(wbif.err_unalloc), 32'(m_err));
    end
  endtask

  task automatic model_update();
    logic        mem_req;
    logic        alu_win;
    logic        mem_win;
    int          sz;
    reg_addr_t   rd;
    word_t       data;
    logic [31:0] nb;
    if (rst) begin
      m_busy      = 32'd0;
      m_q.delete();
      m_turn_alu  = 1'b0;
      m_we3       = 1'b0;
      m_a3        = 5'd0;
      m_wd3       = 32'd0;
      m_err       = 1'b0;
      m_known     = 1'b1;
      m_alu_taken = 1'b1;
    end else begin
      sz      = m_q.size();
      mem_req = (sz != 0);
      alu_win = exp_alu_win();
      mem_win = mem_req && !alu_win;
      if (mem_req && wbif.alu_valid) m_turn_alu = mem_win;
      rd   = mem_win ? m_q[0].rd : wbif.alu_rd;
      data = mem_win ? m_q[0].data : wbif.alu_data;
      nb = m_busy;
      if (m_we3) nb[m_a3] = 1'b0;
      if (wbif.alloc_valid && (wbif.alloc_rd != 5'd0) && !m_busy[wbif.alloc_rd])
        nb[wbif.alloc_rd] = 1'b1;
      if (alu_win || mem_win) begin
        if ((rd != 5'd0) && !m_busy[rd]) m_err = 1'b1;
        m_we3 = (rd != 5'd0);
        m_a3  = rd;
        m_wd3 = data;
      end else begin
        m_we3 = 1'b0;
      end
      if (mem_win) void'(m_q.pop_front());
      if (wbif.mem_valid && (sz < 4)) m_q.push_back('{rd: wbif.mem_rd, data: wbif.mem_data});
      m_busy      = nb;
      m_alu_taken = alu_win;
    end
  endtask

  // Retired loads in the watched range must come out in push order.
  task automatic watch_mem();
    wb_entry_t e;
    if (wbif.we3 && (wbif.a3 >= 5'd10) && (wbif.a3 < 5'd20)) begin
      chk("fifo_retire_expected", 32'(fifo_order.size() != 0), 32'd1);
      if (fifo_order.size() != 0) begin
        e = fifo_order.pop_front();
        chk("fifo_order_rd", 32'(wbif.a3), 32'(e.rd));
        chk("fifo_order_data", wbif.wd3, e.data);
      end
    end
  endtask

  task automatic cycle();
    #1;
    model_check();
    if (watch_en) watch_mem();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive_idle();
    wbif.alloc_valid = 1'b0;
    wbif.alloc_rd    = 5'd0;
    wbif.alu_valid   = 1'b0;
    wbif.alu_rd      = 5'd0;
    wbif.alu_data    = 32'd0;
    wbif.mem_valid   = 1'b0;
    wbif.mem_rd      = 5'd0;
    wbif.mem_data    = 32'd0;
    wbif.q1          = 5'd0;
    wbif.q2          = 5'd0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive_idle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int   exp_a3[4];
    int   alu_cnt;
    logic popped;
    exp_a3 = '{2, 1, 2, 1};

    // Reset state
    rst = 1'b1;
    drive_idle();
    cycle();
    reset_dut();
    #1;
    chk("rst_we3", 32'(wbif.we3), 32'd0);
    chk("rst_a3", 32'(wbif.a3), 32'd0);
    chk("rst_wd3", wbif.wd3, 32'd0);
    chk("rst_err", 32'(wbif.err_unalloc), 32'd0);
    chk("rst_mem_ready", 32'(wbif.mem_ready), 32'd1);
    chk("rst_alu_ready", 32'(wbif.alu_ready), 32'd0);

    // Allocate x5, retire it from the ALU, busy clears two cycles later
    wbif.alloc_valid = 1'b1;
    wbif.alloc_rd    = 5'd5;
    #1 chk("alloc5_ready", 32'(wbif.alloc_ready), 32'd1);
    cycle();
    wbif.alloc_valid = 1'b0;
    wbif.q1          = 5'd5;
    #1 chk("busy5_set", 32'(wbif.busy1), 32'd1);
    wbif.alu_valid = 1'b1;
    wbif.alu_rd    = 5'd5;
    wbif.alu_data  = 32'hDEAD_BEEF;
    #1 chk("alu5_ready", 32'(wbif.alu_ready), 32'd1);
    cycle();
    wbif.alu_valid = 1'b0;
    #1;
    chk("alu5_we3", 32'(wbif.we3), 32'd1);
    chk("alu5_a3", 32'(wbif.a3), 32'd5);
    chk("alu5_wd3", wbif.wd3, 32'hDEAD_BEEF);
    chk("busy5_during_retire", 32'(wbif.busy1), 32'd1);
    cycle();
    #1 chk("busy5_cleared", 32'(wbif.busy1), 32'd0);

    // Re-allocation of a busy register is refused; x0 is always free
    wbif.alloc_valid = 1'b1;
    wbif.alloc_rd    = 5'd7;
    cycle();
    #1 chk("realloc7_blocked", 32'(wbif.alloc_ready), 32'd0);
    cycle();
    wbif.alloc_rd = 5'd0;
    #1 chk("alloc0_ready", 32'(wbif.alloc_ready), 32'd1);
    cycle();
    wbif.alloc_valid = 1'b0;
    wbif.q1          = 5'd0;
    wbif.q2          = 5'd7;
    #1;
    chk("busy0_never", 32'(wbif.busy1), 32'd0);
    chk("busy7_held", 32'(wbif.busy2), 32'd1);
    wbif.alu_valid = 1'b1;
    wbif.alu_rd    = 5'd7;
    wbif.alu_data  = 32'h0000_0077;
    cycle();
    wbif.alu_valid = 1'b0;
    cycle();
    cycle();

    // Continuous contention: ALU x1 vs loads to x2 alternate
    reset_dut();
    wbif.alu_valid = 1'b1;
    wbif.alu_rd    = 5'd1;
    wbif.alu_data  = 32'h1111_0001;
    wbif.mem_valid = 1'b1;
    wbif.mem_rd    = 5'd2;
    alu_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      wbif.mem_data = 32'h2222_0000 + 32'(i);
      #1;
      if (i >= 1 && wbif.alu_ready) alu_cnt++;
      if (i >= 2 && i <= 5) begin
        chk("rr_we3", 32'(wbif.we3), 32'd1);
        chk("rr_a3_seq", 32'(wbif.a3), 32'(exp_a3[i-2]));
      end
      cycle();
    end
    chk("rr_alu_share", 32'(alu_cnt), 32'd3);
    wbif.mem_valid = 1'b0;
    wbif.alu_valid = 1'b0;
    for (int i = 0; i < 6; i++) cycle();

    // Fill the load queue under ALU contention, then drain in order
    reset_dut();
    fifo_order.delete();
    watch_en       = 1'b1;
    wbif.alu_valid = 1'b1;
    wbif.alu_rd    = 5'd3;
    wbif.alu_data  = 32'h0303_0303;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!wbif.mem_ready) break;
      wbif.mem_valid = 1'b1;
      wbif.mem_rd    = 5'(10 + (k % 8));
      wbif.mem_data  = 32'hA000_0000 + 32'(k);
      fifo_order.push_back('{rd: wbif.mem_rd, data: wbif.mem_data});
      cycle();
    end
    wbif.mem_valid = 1'b0;
    chk("fill_ready_low", 32'(wbif.mem_ready), 32'd0);
    popped = 1'b0;
    for (int k = 0; k < 4; k++) begin
      popped = !wbif.alu_ready;
      cycle();
      if (popped) begin
        chk("ready_after_pop", 32'(wbif.mem_ready), 32'd1);
        break;
      end
    end
    chk("pop_seen", 32'(popped), 32'd1);
    for (int k = 0; k < 16; k++) begin
      if (wbif.alu_valid && wbif.alu_ready) begin
        cycle();
        wbif.alu_valid = 1'b0;
      end else begin
        cycle();
      end
    end
    chk("fifo_drained", 32'(fifo_order.size()), 32'd0);
    watch_en = 1'b0;

    // x0 writes are consumed silently; an unreserved register flags an error
    reset_dut();
    wbif.alu_valid = 1'b1;
    wbif.alu_rd    = 5'd0;
    wbif.alu_data  = 32'h0000_1234;
    #1 chk("x0_alu_ready", 32'(wbif.alu_ready), 32'd1);
    cycle();
    wbif.alu_valid = 1'b0;
    #1;
    chk("x0_we3", 32'(wbif.we3), 32'd0);
    chk("x0_err", 32'(wbif.err_unalloc), 32'd0);
    wbif.alu_valid = 1'b1;
    wbif.alu_rd    = 5'd9;
    wbif.alu_data  = 32'h9999_0009;
    cycle();
    wbif.alu_valid = 1'b0;
    #1;
    chk("unalloc_we3", 32'(wbif.we3), 32'd1);
    chk("unalloc_a3", 32'(wbif.a3), 32'd9);
    chk("unalloc_err", 32'(wbif.err_unalloc), 32'd1);
    for (int i = 0; i < 3; i++) cycle();
    #1 chk("err_sticky", 32'(wbif.err_unalloc), 32'd1);
    reset_dut();
    #1 chk("err_cleared_by_rst", 32'(wbif.err_unalloc), 32'd0);

    // Reset with three loads queued and a write in flight
    reset_dut();
    wbif.alloc_valid = 1'b1;
    wbif.alloc_rd    = 5'd4;
    wbif.alu_valid   = 1'b1;
    wbif.alu_rd      = 5'd6;
    wbif.alu_data    = 32'h0606_0606;
    wbif.mem_valid   = 1'b1;
    wbif.mem_rd      = 5'd12;
    for (int i = 0; i < 5; i++) begin
      wbif.mem_data = 32'hC000_0000 + 32'(i);
      cycle();
      wbif.alloc_valid = 1'b0;
    end
    #1 chk("pre_rst_we3", 32'(wbif.we3), 32'd1);
    rst = 1'b1;
    drive_idle();
    cycle();
    rst = 1'b0;
    wbif.q1 = 5'd4;
    wbif.q2 = 5'd6;
    #1;
    chk("post_rst_we3", 32'(wbif.we3), 32'd0);
    chk("post_rst_mem_ready", 32'(wbif.mem_ready), 32'd1);
    chk("post_rst_busy4", 32'(wbif.busy1), 32'd0);
    chk("post_rst_busy6", 32'(wbif.busy2), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("no_ghost_retire", 32'(wbif.we3), 32'd0);
      cycle();
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst              = ($urandom_range(0, 99) == 0);
      wbif.alloc_valid = ($urandom_range(0, 2) == 0);
      wbif.alloc_rd    = 5'($urandom_range(0, 31));
      if (!wbif.alu_valid || m_alu_taken) begin
        wbif.alu_valid = ($urandom_range(0, 1) == 1);
        wbif.alu_rd    = 5'($urandom_range(0, 31));
        wbif.alu_data  = $urandom();
      end
      wbif.mem_valid = ($urandom_range(0, 1) == 1);
      wbif.mem_rd    = 5'($urandom_range(0, 31));
      wbif.mem_data  = $urandom();
      wbif.q1        = 5'($urandom_range(0, 31));
      wbif.q2        = 5'($urandom_range(0, 31));
      cycle();
    end
    rst = 1'b0;
    drive_idle();
    for (int i = 0; i < 8; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
